// File: rtl/vga_sram_scanout_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_sram_scanout_if
// Purpose  : Pin bundle for an asynchronous 16-bit SRAM frame buffer port.
// Revision : 1.0
// ============================================================================
interface vga_sram_scanout_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] Address_OUT;
    wire  [15:0]       Data_IO;
    logic              Chip_EN;
    logic              Write_EN;
    logic              Out_EN;
    logic              LB;
    logic              UB;

    modport master (
        output Address_OUT, Chip_EN, Write_EN, Out_EN, LB, UB,
        inout  Data_IO
    );

    modport slave (
        input  Address_OUT, Chip_EN, Write_EN, Out_EN, LB, UB,
        inout  Data_IO
    );
endinterface
`default_nettype wire

// File: rtl/vga_sram_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vga_sram_scanout
// Purpose  : VGA timing + SRAM pixel fetch (RGB332/RGB565) to RGB DAC pins.
//            Optional page flipping with macro DOUBLE_BUFFER_EN.
// Revision : 1.0
// ============================================================================
module vga_sram_scanout #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 23,
    parameter int SYNC_POL   = 1,
    parameter int BPP        = 8,
    parameter int ADDR_W     = 19,
    parameter int COLOR_W    = 4,
    parameter int READ_LAT   = 1,
    parameter int PAGE1_BASE = 240000
) (
    input  wire logic        CLOCK,
    input  wire logic        RESET,
    output logic             H_Sync,
    output logic             V_Sync,
    output logic [COLOR_W-1:0] R_out,
    output logic [COLOR_W-1:0] G_out,
    output logic [COLOR_W-1:0] B_out,
    output logic             Frame_Start,
`ifdef DOUBLE_BUFFER_EN
    input  wire logic        Page_Sel,
`endif
    vga_sram_scanout_if.master sram
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_H_W     = $clog2(c_H_TOTAL + 1);
    localparam int c_V_W     = $clog2(c_V_TOTAL + 1);

    localparam logic [c_H_W-1:0] c_H_LAST  = c_H_W'(c_H_TOTAL - 1);
    localparam logic [c_H_W-1:0] c_H_ACT   = c_H_W'(H_ACTIVE);
    localparam logic [c_H_W-1:0] c_HS_BEG  = c_H_W'(H_ACTIVE + H_FP);
    localparam logic [c_H_W-1:0] c_HS_END  = c_H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_V_W-1:0] c_V_LAST  = c_V_W'(c_V_TOTAL - 1);
    localparam logic [c_V_W-1:0] c_V_ACT   = c_V_W'(V_ACTIVE);
    localparam logic [c_V_W-1:0] c_VS_BEG  = c_V_W'(V_ACTIVE + V_FP);
    localparam logic [c_V_W-1:0] c_VS_END  = c_V_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic c_SP = (SYNC_POL != 0);

    // Channel placement inside the (byte-selected) pixel word
    localparam int c_R_LSB = (BPP == 16) ? 11 : 5;
    localparam int c_R_W   = (BPP == 16) ? 5  : 3;
    localparam int c_G_LSB = (BPP == 16) ? 5  : 2;
    localparam int c_G_W   = (BPP == 16) ? 6  : 3;
    localparam int c_B_LSB = 0;
    localparam int c_B_W   = (BPP == 16) ? 5  : 2;
    localparam logic [15:0] c_R_MASK = 16'((1 << c_R_W) - 1);
    localparam logic [15:0] c_G_MASK = 16'((1 << c_G_W) - 1);
    localparam logic [15:0] c_B_MASK = 16'((1 << c_B_W) - 1);

    generate
        if (BPP != 8 && BPP != 16) begin : g_bad_bpp
            $error("vga_sram_scanout: BPP must be 8 or 16");
        end
        if (BPP == 8 && (H_ACTIVE % 2) != 0) begin : g_bad_hact
            $error("vga_sram_scanout: H_ACTIVE must be even for BPP=8");
        end
        if (COLOR_W < 3 || COLOR_W > 8) begin : g_bad_cw
            $error("vga_sram_scanout: COLOR_W must be 3..8");
        end
        if (READ_LAT < 1 || READ_LAT > 3) begin : g_bad_lat
            $error("vga_sram_scanout: READ_LAT must be 1..3");
        end
    endgenerate

    // Left-justify a w-bit channel, replicating its MSBs when COLOR_W > w
    function automatic logic [COLOR_W-1:0] f_expand(input logic [7:0] ch, input int w);
        logic [COLOR_W-1:0] res;
        res = '0;
        for (int i = 0; i < COLOR_W; i++) begin
            res[COLOR_W-1-i] = ch[w-1-(i % w)];
        end
        return res;
    endfunction

    logic [c_H_W-1:0]  r_h;
    logic [c_V_W-1:0]  r_v;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_data;
    logic [4:0]        r_side [READ_LAT];

    logic              w_active;
    logic              w_origin;
    logic              w_hs;
    logic              w_vs;
    logic              w_x0;
    logic              w_inc;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_addr;
    logic [4:0]        w_side;
    logic [4:0]        w_tap;
    logic [15:0]       w_word;
    logic [7:0]        w_r_ch;
    logic [7:0]        w_g_ch;
    logic [7:0]        w_b_ch;

    assign w_active = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_origin = (r_h == '0) && (r_v == '0);
    assign w_hs     = (r_h >= c_HS_BEG) && (r_h < c_HS_END);
    assign w_vs     = (r_v >= c_VS_BEG) && (r_v < c_VS_END);
    assign w_x0     = (BPP == 8) ? r_h[0] : 1'b0;
    assign w_inc    = w_active && ((BPP == 16) || r_h[0]);

`ifdef DOUBLE_BUFFER_EN
    assign w_base = Page_Sel ? ADDR_W'(PAGE1_BASE) : '0;
`else
    assign w_base = '0;
`endif

    // The frame base is presented directly on the origin cycle so pixel (0,0)
    // already reads from the page selected for this frame.
    assign w_addr = w_origin ? w_base : r_addr;

    assign sram.Address_OUT = w_addr;
    assign sram.Chip_EN     = 1'b0;
    assign sram.Write_EN    = 1'b1;
    assign sram.Out_EN      = 1'b0;
    assign sram.LB          = 1'b0;
    assign sram.UB          = 1'b0;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == c_H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_addr <= '0;
        end else if (w_active) begin
            r_addr <= w_addr + {{(ADDR_W-1){1'b0}}, w_inc};
        end
    end

    // Sideband travels READ_LAT stages to meet the sampled SRAM word
    assign w_side = {w_origin, w_active, w_vs, w_hs, w_x0};

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_data <= '0;
            for (int i = 0; i < READ_LAT; i++) r_side[i] <= '0;
        end else begin
            r_data    <= sram.Data_IO;
            r_side[0] <= w_side;
            for (int i = 1; i < READ_LAT; i++) r_side[i] <= r_side[i-1];
        end
    end

    assign w_tap  = r_side[READ_LAT-1];
    assign w_word = {r_data[15:8], w_tap[0] ? r_data[15:8] : r_data[7:0]};
    assign w_r_ch = 8'((w_word >> c_R_LSB) & c_R_MASK);
    assign w_g_ch = 8'((w_word >> c_G_LSB) & c_G_MASK);
    assign w_b_ch = 8'((w_word >> c_B_LSB) & c_B_MASK);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            H_Sync      <= ~c_SP;
            V_Sync      <= ~c_SP;
            Frame_Start <= 1'b0;
            R_out       <= '0;
            G_out       <= '0;
            B_out       <= '0;
        end else begin
            H_Sync      <= w_tap[1] ? c_SP : ~c_SP;
            V_Sync      <= w_tap[2] ? c_SP : ~c_SP;
            Frame_Start <= w_tap[4];
            R_out       <= w_tap[3] ? f_expand(w_r_ch, c_R_W) : '0;
            G_out       <= w_tap[3] ? f_expand(w_g_ch, c_G_W) : '0;
            B_out       <= w_tap[3] ? f_expand(w_b_ch, c_B_W) : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sram_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sram_scanout
// Purpose  : Checks an 8bpp and a 16bpp scan-out against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_vga_sram_scanout;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int AW = 19;
    localparam int P1 = 240000;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef DOUBLE_BUFFER_EN
    logic page_sel = 1'b0;
`endif
    always #5 clk = ~clk;

    vga_sram_scanout_if #(.ADDR_W(AW)) bus8 ();
    vga_sram_scanout_if #(.ADDR_W(AW)) bus16 ();

    logic       hs8, vs8, fs8, hs16, vs16, fs16;
    logic [3:0] r8, g8, b8, r16, g16, b16;

    vga_sram_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1), .BPP(8), .ADDR_W(AW), .COLOR_W(4), .READ_LAT(1),
        .PAGE1_BASE(P1)
    ) u8 (
        .CLOCK(clk), .RESET(rst), .H_Sync(hs8), .V_Sync(vs8),
        .R_out(r8), .G_out(g8), .B_out(b8), .Frame_Start(fs8),
`ifdef DOUBLE_BUFFER_EN
        .Page_Sel(page_sel),
`endif
        .sram(bus8.master)
    );

    vga_sram_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0), .BPP(16), .ADDR_W(AW), .COLOR_W(4), .READ_LAT(2),
        .PAGE1_BASE(P1)
    ) u16 (
        .CLOCK(clk), .RESET(rst), .H_Sync(hs16), .V_Sync(vs16),
        .R_out(r16), .G_out(g16), .B_out(b16), .Frame_Start(fs16),
`ifdef DOUBLE_BUFFER_EN
        .Page_Sel(page_sel),
`endif
        .sram(bus16.master)
    );

    // SRAM models: the 16bpp instance sees one extra clock of access time
    logic [15:0]   mem8  [0:(1<<AW)-1];
    logic [15:0]   mem16 [0:(1<<AW)-1];
    logic [AW-1:0] a16_d = '0;
    always @(posedge clk) a16_d <= bus16.Address_OUT;
    assign bus8.Data_IO  = mem8[bus8.Address_OUT];
    assign bus16.Data_IO = mem16[a16_d];

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;
    int lit_run = 0;
    bit chk_en  = 1'b0;
    int base_f [256];

    always @(posedge clk) k <= rst ? 0 : k + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (k=%0d)", nm, act, exp, k);
        end
    endtask

    function automatic int f_expand(input int ch, input int w, input int cw);
        int rep  = 0;
        int bits = 0;
        while (bits < cw) begin
            rep  = (rep << w) | ch;
            bits = bits + w;
        end
        return (rep >> (bits - cw)) & ((1 << cw) - 1);
    endfunction

    function automatic int f_addr(input int pos, input int bpp);
        int h   = pos % HT;
        int v   = (pos / HT) % VT;
        int f   = (pos / FT) % 256;
        int off = (v < VA) ? v * HA + ((h < HA) ? h : HA) : VA * HA;
        return (base_f[f] + off / (16 / bpp)) % (1 << AW);
    endfunction

    function automatic void f_expect(input int kk, input int bpp, input int lat, input int pol,
                                     output int ehs, output int evs, output int efs,
                                     output int er, output int eg, output int eb);
        int p, h, v, a, d, by;
        ehs = 1 - pol; evs = 1 - pol; efs = 0; er = 0; eg = 0; eb = 0;
        if (kk < lat + 1) return;
        p = kk - (lat + 1);
        h = p % HT;
        v = (p / HT) % VT;
        if (h >= HA + HF && h < HA + HF + HS) ehs = pol;
        if (v >= VA + VF && v < VA + VF + VS) evs = pol;
        efs = (p % FT == 0) ? 1 : 0;
        if (h < HA && v < VA) begin
            a = f_addr(p, bpp);
            if (bpp == 8) begin
                d  = int'(mem8[a]);
                by = (h % 2 == 1) ? (d >> 8) : (d & 255);
                er = f_expand((by >> 5) & 7, 3, 4);
                eg = f_expand((by >> 2) & 7, 3, 4);
                eb = f_expand(by & 3, 2, 4);
            end else begin
                d  = int'(mem16[a]);
                er = f_expand((d >> 11) & 31, 5, 4);
                eg = f_expand((d >> 5) & 63, 6, 4);
                eb = f_expand(d & 31, 5, 4);
            end
        end
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        int ehs, evs, efs, er, eg, eb;
        if (chk_en) begin
            if (k % FT == 0) begin
`ifdef DOUBLE_BUFFER_EN
                base_f[(k / FT) % 256] = page_sel ? P1 : 0;
`else
                base_f[(k / FT) % 256] = 0;
`endif
            end
            check("u8_addr", int'(bus8.Address_OUT), f_addr(k, 8));
            check("u16_addr", int'(bus16.Address_OUT), f_addr(k, 16));
            f_expect(k, 8, 1, 1, ehs, evs, efs, er, eg, eb);
            check("u8_hsync", int'(hs8), ehs);
            check("u8_vsync", int'(vs8), evs);
            check("u8_fstart", int'(fs8), efs);
            check("u8_red", int'(r8), er);
            check("u8_green", int'(g8), eg);
            check("u8_blue", int'(b8), eb);
            f_expect(k, 16, 2, 0, ehs, evs, efs, er, eg, eb);
            check("u16_hsync", int'(hs16), ehs);
            check("u16_vsync", int'(vs16), evs);
            check("u16_fstart", int'(fs16), efs);
            check("u16_red", int'(r16), er);
            check("u16_green", int'(g16), eg);
            check("u16_blue", int'(b16), eb);
            check("u8_ctrl", int'({bus8.Chip_EN, bus8.Write_EN, bus8.Out_EN, bus8.LB, bus8.UB}), 8);
            check("u16_ctrl", int'({bus16.Chip_EN, bus16.Write_EN, bus16.Out_EN, bus16.LB, bus16.UB}), 8);
        end
    end

    // Hand-computed expectations that pin the model
    always @(negedge clk) begin
        if (lit_run != 0) begin
            if (k == 0) begin
                check("lit_rst_addr", int'(bus8.Address_OUT), 0);
                check("lit_rst_red", int'(r8), 0);
                check("lit_rst_hs8", int'(hs8), 0);
                check("lit_rst_hs16", int'(hs16), 1);
                check("lit_rst_fs", int'(fs8), 0);
            end
            if (k == 1) check("lit_addr_x1", int'(bus8.Address_OUT), 0);
            if (k == 2) begin
                check("lit_addr_x2", int'(bus8.Address_OUT), 1);
                check("lit_px0_r", int'(r8), 0);
                check("lit_px0_g", int'(g8), 15);
                check("lit_px0_b", int'(b8), 0);
                check("lit_fs8", int'(fs8), 1);
            end
            if (k == 3) begin
                check("lit_addr_x3", int'(bus8.Address_OUT), 1);
                check("lit_px1_r", int'(r8), 15);
                check("lit_px1_g", int'(g8), 0);
                check("lit_px1_b", int'(b8), 0);
                check("lit_565_r", int'(r16), 15);
                check("lit_565_g", int'(g16), 0);
                check("lit_565_b", int'(b16), 0);
                check("lit_fs16", int'(fs16), 1);
            end
            if (k == 4)  check("lit_addr_x4", int'(bus8.Address_OUT), 2);
            if (k == 19) check("lit_hs_pre", int'(hs8), 0);
            if (k == 20) check("lit_hs_on", int'(hs8), 1);
            if (k == 23) check("lit_hs_last", int'(hs8), 1);
            if (k == 24) begin
                check("lit_hs_off", int'(hs8), 0);
                check("lit_blank_hold", int'(bus8.Address_OUT), 8);
            end
            if (k == HA) check("lit_blank_addr", int'(bus8.Address_OUT), 8);
            if (k == HT) begin
                check("lit_line1_addr8", int'(bus8.Address_OUT), 8);
                check("lit_line1_addr16", int'(bus16.Address_OUT), 16);
            end
            if (k == FT + 2) check("lit_fs8_period", int'(fs8), 1);
            if (k == FT)     check("lit_frame1_base", int'(bus8.Address_OUT), 0);
            if (k == 2 * FT && lit_run == 1) begin
`ifdef DOUBLE_BUFFER_EN
                check("lit_page_flip", int'(bus8.Address_OUT), P1);
`else
                check("lit_page_flip", int'(bus8.Address_OUT), 0);
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem8[i]  = 16'($urandom);
            mem16[i] = 16'($urandom);
        end
        mem8[0]  = 16'hE01C;
        mem16[0] = 16'hF800;
        chk_en  = 1'b1;
        lit_run = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Request page 1 in the middle of frame 1 (line 3)
        repeat (FT + 3 * HT) @(posedge clk);
`ifdef DOUBLE_BUFFER_EN
        #1 page_sel = 1'b1;
`endif
        repeat (FT - 3 * HT + 10) @(posedge clk);
        #1 lit_run = 0;

        for (int c = 0; c < 2 * FT; c++) begin
            @(posedge clk);
`ifdef DOUBLE_BUFFER_EN
            #1 if ($urandom_range(0, 49) == 0) page_sel = ~page_sel;
`endif
        end

        // Reset mid-frame at line 3, pixel 10
        repeat ((FT - (k % FT) + 3 * HT + 10) % FT) @(posedge clk);
        #1;
        rst     = 1'b1;
        lit_run = 2;
`ifdef DOUBLE_BUFFER_EN
        page_sel = 1'b0;
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * FT + 5) @(posedge clk);
        @(negedge clk);
        chk_en  = 1'b0;
        lit_run = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
